// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI4 slave-side bus (AW/W/B/AR/R plus AC snoop) between memory master and responder.
interface axi_mem_responder_if #(
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ID_WIDTH-1:0]   s_axi_awid;
   logic [ADDR_WIDTH-1:0] s_axi_awaddr;
   logic [7:0]            s_axi_awlen;
   logic [2:0]            s_axi_awsize;
   logic [1:0]            s_axi_awburst;
   logic                  s_axi_awvalid;
   logic                  s_axi_awready;
   logic [DATA_WIDTH-1:0] s_axi_wdata;
   logic [STRB_WIDTH-1:0] s_axi_wstrb;
   logic                  s_axi_wlast;
   logic                  s_axi_wvalid;
   logic                  s_axi_wready;
   logic [ID_WIDTH-1:0]   s_axi_bid;
   logic [1:0]            s_axi_bresp;
   logic                  s_axi_bvalid;
   logic                  s_axi_bready;
   logic [ID_WIDTH-1:0]   s_axi_arid;
   logic [ADDR_WIDTH-1:0] s_axi_araddr;
   logic [7:0]            s_axi_arlen;
   logic [2:0]            s_axi_arsize;
   logic [1:0]            s_axi_arburst;
   logic                  s_axi_arvalid;
   logic                  s_axi_arready;
   logic [ID_WIDTH-1:0]   s_axi_rid;
   logic [DATA_WIDTH-1:0] s_axi_rdata;
   logic [1:0]            s_axi_rresp;
   logic                  s_axi_rlast;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready;
   logic                  s_axi_acvalid;
   logic [ADDR_WIDTH-1:0] s_axi_acaddr;
   logic [3:0]            s_axi_acsnoop;
   logic                  s_axi_acready;
   modport slave (
      input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
      input  s_axi_rready, s_axi_acready,
      output s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
      output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      output s_axi_acvalid, s_axi_acaddr, s_axi_acsnoop
   );
   modport master (
      output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
      output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
      output s_axi_rready, s_axi_acready,
      input  s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
      input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      input  s_axi_acvalid, s_axi_acaddr, s_axi_acsnoop
   );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-outstanding AXI4 memory model with FIXED/INCR/WRAP bursts and byte strobes.
// Define AXI_SNOOP_EN to send one AC invalidate of the written 64-byte line before each B response.
module axi_mem_responder #(
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int MEM_WORDS  = 4096
) (
   input logic clk,
   input logic reset,
   axi_mem_responder_if.slave s
);
   localparam int IW = $clog2(MEM_WORDS);
   typedef enum logic [2:0] {
      IDLE, RD, WR_DATA, WR_RESP
`ifdef AXI_SNOOP_EN
      , WR_SNOOP
`endif
   } state_t;
`ifdef AXI_SNOOP_EN
   localparam state_t WR_NEXT = WR_SNOOP;
`else
   localparam state_t WR_NEXT = WR_RESP;
`endif
   state_t state_q, state_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, step, mask, nxt;
   logic [7:0] len_q, len_d, beat_q, beat_d;
   logic [2:0] size_q, size_d;
   logic [1:0] burst_q, burst_d, err_q, err_d, beat_resp;
   logic rdy_q, rdy_d, ar_hs, aw_hs, r_hs, w_hs, oor, bad;
   logic [IW-1:0] idx;
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   assign idx = addr_q[IW+2:3];
   assign oor = |addr_q[ADDR_WIDTH-1:IW+3];
   assign bad = size_q > 3'd3 || (burst_q == 2'b10 && !(len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15));
   assign beat_resp = bad ? 2'b10 : oor ? 2'b11 : 2'b00;
   assign step = ADDR_WIDTH'(1) << size_q;
   assign mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
   assign nxt = burst_q == 2'b00 ? addr_q : burst_q == 2'b10 ? (addr_q & ~mask) | ((addr_q + step) & mask) : addr_q + step;
   // Ready is a flop so both readies stay low through reset; reads win over writes in IDLE
   assign ar_hs = rdy_q && s.s_axi_arvalid;
   assign aw_hs = rdy_q && !s.s_axi_arvalid && s.s_axi_awvalid;
   assign r_hs = state_q == RD && s.s_axi_rready;
   assign w_hs = state_q == WR_DATA && s.s_axi_wvalid;
   assign s.s_axi_arready = rdy_q;
   assign s.s_axi_awready = rdy_q && !s.s_axi_arvalid;
   assign s.s_axi_rvalid = state_q == RD;
   assign s.s_axi_rdata = (state_q == RD && beat_resp == 2'b00) ? mem[idx] : '0;
   assign s.s_axi_rresp = state_q == RD ? beat_resp : 2'b00;
   assign s.s_axi_rlast = state_q == RD && beat_q == len_q;
   assign s.s_axi_rid = state_q == RD ? id_q : '0;
   assign s.s_axi_wready = state_q == WR_DATA;
   assign s.s_axi_bvalid = state_q == WR_RESP;
   assign s.s_axi_bid = state_q == WR_RESP ? id_q : '0;
   assign s.s_axi_bresp = state_q == WR_RESP ? err_q : 2'b00;
`ifdef AXI_SNOOP_EN
   logic [ADDR_WIDTH-1:0] start_q, start_d;
   assign s.s_axi_acvalid = state_q == WR_SNOOP;
   assign s.s_axi_acaddr = state_q == WR_SNOOP ? {start_q[ADDR_WIDTH-1:6], 6'b0} : '0;
   assign s.s_axi_acsnoop = state_q == WR_SNOOP ? 4'hD : 4'h0;
   always_comb begin
      start_d = aw_hs ? s.s_axi_awaddr : start_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) start_q <= '0;
      else start_q <= start_d;
   end
`else
   assign s.s_axi_acvalid = 1'b0;
   assign s.s_axi_acaddr = '0;
   assign s.s_axi_acsnoop = 4'h0;
`endif
   always_comb begin
      state_d = state_q;
      id_d = id_q;
      addr_d = addr_q;
      len_d = len_q;
      size_d = size_q;
      burst_d = burst_q;
      beat_d = beat_q;
      err_d = err_q;
      if (ar_hs) begin
         {id_d, addr_d, len_d, size_d, burst_d} = {s.s_axi_arid, s.s_axi_araddr, s.s_axi_arlen, s.s_axi_arsize, s.s_axi_arburst};
         {beat_d, err_d, state_d} = {8'd0, 2'b00, RD};
      end else if (aw_hs) begin
         {id_d, addr_d, len_d, size_d, burst_d} = {s.s_axi_awid, s.s_axi_awaddr, s.s_axi_awlen, s.s_axi_awsize, s.s_axi_awburst};
         {beat_d, err_d, state_d} = {8'd0, 2'b00, WR_DATA};
      end
      if (r_hs) begin
         addr_d = nxt;
         beat_d = beat_q + 8'd1;
         state_d = beat_q == len_q ? IDLE : RD;
      end
      // Error codes are 00/10/11, so OR-accumulation yields the worst response
      if (w_hs) begin
         addr_d = nxt;
         beat_d = beat_q + 8'd1;
         err_d = err_q | beat_resp | ((s.s_axi_wlast && beat_q != len_q) ? 2'b10 : 2'b00);
         state_d = s.s_axi_wlast ? WR_NEXT : WR_DATA;
      end
`ifdef AXI_SNOOP_EN
      if (state_q == WR_SNOOP && s.s_axi_acready) state_d = WR_RESP;
`endif
      if (state_q == WR_RESP && s.s_axi_bready) state_d = IDLE;
      rdy_d = state_d == IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         {id_q, addr_q, len_q, size_q, burst_q, beat_q, err_q, rdy_q} <= '0;
      end else begin
         state_q <= state_d;
         {id_q, addr_q, len_q, size_q, burst_q, beat_q, err_q, rdy_q} <= {id_d, addr_d, len_d, size_d, burst_d, beat_d, err_d, rdy_d};
      end
   end
   always_ff @(posedge clk) begin
      if (w_hs && beat_resp == 2'b00)
         for (int b = 0; b < STRB_WIDTH; b++)
            if (s.s_axi_wstrb[b]) mem[idx][8*b +: 8] <= s.s_axi_wdata[8*b +: 8];
   end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed checks of bursts, strobes, wrap, backpressure, errors and snoop.
module tb_axi_mem_responder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int errors = 0;
   int checks = 0;
   logic [63:0] wd [16];
   logic [63:0] rd [16];
   logic [1:0] rr [16];
   logic rl [16];
   logic [12:0] rid_seen;
`ifdef AXI_SNOOP_EN
   localparam int BLAT = 1;
`else
   localparam int BLAT = 0;
`endif
   always #5 clk = ~clk;
   axi_mem_responder_if bus ();
   axi_mem_responder dut (.clk(clk), .reset(reset), .s(bus));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int nb, input logic [7:0] strb, input int bdelay,
                           output logic [1:0] resp, output logic [12:0] bid, output int blat, output logic bheld);
      int t;
      bus.s_axi_awid = 13'h5; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len;
      bus.s_axi_awsize = size; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
      t = 0;
      while (!bus.s_axi_awready && t < 50) begin step(); t++; end
      checks++; if (t >= 50) begin errors++; $display("FAIL aw_timeout: waited %0d cycles, limit 50", t); end
      step();
      bus.s_axi_awvalid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = wd[i]; bus.s_axi_wstrb = strb; bus.s_axi_wlast = (i == nb - 1);
         t = 0;
         while (!bus.s_axi_wready && t < 50) begin step(); t++; end
         checks++; if (t >= 50) begin errors++; $display("FAIL w_timeout: beat %0d waited %0d cycles", i, t); end
         step();
      end
      bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
      blat = 0;
      while (!bus.s_axi_bvalid && blat < 50) begin step(); blat++; end
      bheld = 1'b1;
      repeat (bdelay) begin step(); bheld &= bus.s_axi_bvalid; end
      bus.s_axi_bready = 1'b1;
      resp = bus.s_axi_bresp;
      bid = bus.s_axi_bid;
      step();
      bus.s_axi_bready = 1'b0;
   endtask

   task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input int stall_at, input int stall_n, output int lat, output logic held);
      int t;
      bus.s_axi_arid = 13'h1A3; bus.s_axi_araddr = addr; bus.s_axi_arlen = len;
      bus.s_axi_arsize = size; bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
      t = 0;
      while (!bus.s_axi_arready && t < 50) begin step(); t++; end
      checks++; if (t >= 50) begin errors++; $display("FAIL ar_timeout: waited %0d cycles, limit 50", t); end
      step();
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b1;
      lat = 0;
      while (!bus.s_axi_rvalid && lat < 50) begin step(); lat++; end
      held = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         t = 0;
         while (!bus.s_axi_rvalid && t < 50) begin step(); t++; end
         rd[i] = bus.s_axi_rdata; rr[i] = bus.s_axi_rresp; rl[i] = bus.s_axi_rlast; rid_seen = bus.s_axi_rid;
         if (i == stall_at) begin
            bus.s_axi_rready = 1'b0;
            repeat (stall_n) begin
               step();
               held &= bus.s_axi_rvalid && bus.s_axi_rdata == rd[i] && bus.s_axi_rlast == rl[i];
            end
            bus.s_axi_rready = 1'b1;
         end
         step();
      end
      bus.s_axi_rready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bus.s_axi_arready !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b want 0", bus.s_axi_arready); end
      checks++; if (bus.s_axi_awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b want 0", bus.s_axi_awready); end
      checks++; if (bus.s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", bus.s_axi_rvalid); end
      checks++; if (bus.s_axi_wready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b want 0", bus.s_axi_wready); end
      checks++; if (bus.s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", bus.s_axi_bvalid); end
      checks++; if (bus.s_axi_acvalid !== 1'b0) begin errors++; $display("FAIL rst_acvalid: got %b want 0", bus.s_axi_acvalid); end
      checks++; if (bus.s_axi_rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.s_axi_rdata); end
      checks++; if (bus.s_axi_bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp: got %b want 00", bus.s_axi_bresp); end
      repeat (3) step();
      reset = 1'b0;
      step();
      checks++; if (bus.s_axi_arready !== 1'b1) begin errors++; $display("FAIL post_rst_arready: got %b want 1", bus.s_axi_arready); end
   endtask

   task automatic test_incr();
      logic [1:0] resp; logic [12:0] bid; int blat, lat; logic bheld, held;
      for (int i = 0; i < 8; i++) wd[i] = 64'h11 * 64'(i + 1);
      do_write(64'h100, 8'd7, 3'd3, 2'b01, 8, 8'hFF, 0, resp, bid, blat, bheld);
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b want 00", resp); end
      checks++; if (bid !== 13'h5) begin errors++; $display("FAIL incr_bid: got %h want 5", bid); end
      checks++; if (blat !== BLAT) begin errors++; $display("FAIL incr_blat: got %0d want %0d", blat, BLAT); end
      do_read(64'h100, 8'd7, 3'd3, 2'b01, -1, 0, lat, held);
      checks++; if (lat !== 0) begin errors++; $display("FAIL incr_rlat: got %0d want 0", lat); end
      checks++; if (rid_seen !== 13'h1A3) begin errors++; $display("FAIL incr_rid: got %h want 1a3", rid_seen); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (rd[i] !== 64'h11 * 64'(i + 1)) begin errors++; $display("FAIL incr_rdata[%0d]: got %h want %h", i, rd[i], 64'h11 * 64'(i + 1)); end
         checks++; if (rr[i] !== 2'b00) begin errors++; $display("FAIL incr_rresp[%0d]: got %b want 00", i, rr[i]); end
         checks++; if (rl[i] !== (i == 7)) begin errors++; $display("FAIL incr_rlast[%0d]: got %b want %b", i, rl[i], i == 7); end
      end
      checks++; if (bus.s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL incr_rvalid_end: got %b want 0", bus.s_axi_rvalid); end
   endtask

   task automatic test_strobe();
      logic [1:0] resp; logic [12:0] bid; int blat, lat; logic bheld, held;
      wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      do_write(64'h200, 8'd0, 3'd3, 2'b01, 1, 8'hFF, 0, resp, bid, blat, bheld);
      wd[0] = 64'h0;
      do_write(64'h200, 8'd0, 3'd3, 2'b01, 1, 8'h0F, 0, resp, bid, blat, bheld);
      do_read(64'h200, 8'd0, 3'd3, 2'b01, -1, 0, lat, held);
      checks++; if (rd[0] !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL strobe_rdata: got %h want ffffffff00000000", rd[0]); end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp; logic [12:0] bid; int blat, lat; logic bheld, held;
      do_read(64'h100, 8'd7, 3'd3, 2'b01, 3, 3, lat, held);
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL bp_r_hold: got %b want 1", held); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (rd[i] !== 64'h11 * 64'(i + 1)) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want %h", i, rd[i], 64'h11 * 64'(i + 1)); end
      end
      checks++; if (rl[7] !== 1'b1) begin errors++; $display("FAIL bp_rlast: got %b want 1", rl[7]); end
      wd[0] = 64'hCAFE;
      do_write(64'h300, 8'd0, 3'd3, 2'b01, 1, 8'hFF, 5, resp, bid, blat, bheld);
      checks++; if (bheld !== 1'b1) begin errors++; $display("FAIL bp_b_hold: got %b want 1", bheld); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL bp_bresp: got %b want 00", resp); end
   endtask

   task automatic test_wrap();
      logic [1:0] resp; logic [12:0] bid; int blat, lat; logic bheld, held;
      for (int i = 0; i < 4; i++) wd[i] = 64'(i);
      do_write(64'h100, 8'd3, 3'd3, 2'b01, 4, 8'hFF, 0, resp, bid, blat, bheld);
      do_read(64'h118, 8'd3, 3'd3, 2'b10, -1, 0, lat, held);
      checks++; if (rd[0] !== 64'd3) begin errors++; $display("FAIL wrap_beat0: got %h want 3", rd[0]); end
      checks++; if (rd[1] !== 64'd0) begin errors++; $display("FAIL wrap_beat1: got %h want 0", rd[1]); end
      checks++; if (rd[2] !== 64'd1) begin errors++; $display("FAIL wrap_beat2: got %h want 1", rd[2]); end
      checks++; if (rd[3] !== 64'd2) begin errors++; $display("FAIL wrap_beat3: got %h want 2", rd[3]); end
      checks++; if (rl[3] !== 1'b1 || rl[2] !== 1'b0) begin errors++; $display("FAIL wrap_rlast: got %b%b want 10", rl[3], rl[2]); end
   endtask

   task automatic test_errors();
      logic [1:0] resp; logic [12:0] bid; int blat, lat; logic bheld, held;
      do_read(64'h8000, 8'd0, 3'd3, 2'b01, -1, 0, lat, held);
      checks++; if (rd[0] !== 64'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", rd[0]); end
      checks++; if (rr[0] !== 2'b11) begin errors++; $display("FAIL oor_rresp: got %b want 11", rr[0]); end
      do_read(64'h100, 8'd0, 3'd4, 2'b01, -1, 0, lat, held);
      checks++; if (rr[0] !== 2'b10 || rd[0] !== 64'h0) begin errors++; $display("FAIL size_rd: got resp %b data %h want 10 0", rr[0], rd[0]); end
      do_read(64'h100, 8'd2, 3'd3, 2'b10, -1, 0, lat, held);
      checks++; if (rr[0] !== 2'b10) begin errors++; $display("FAIL wraplen_rresp: got %b want 10", rr[0]); end
      wd[0] = 64'h1; wd[1] = 64'h2;
      do_write(64'h400, 8'd3, 3'd3, 2'b01, 2, 8'hFF, 0, resp, bid, blat, bheld);
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL short_bresp: got %b want 10", resp); end
      do_write(64'h8000, 8'd1, 3'd3, 2'b01, 2, 8'hFF, 0, resp, bid, blat, bheld);
      checks++; if (resp !== 2'b11) begin errors++; $display("FAIL oor_bresp: got %b want 11", resp); end
   endtask

   task automatic test_priority();
      bus.s_axi_arid = 13'h7; bus.s_axi_araddr = 64'h120; bus.s_axi_arlen = 8'd0; bus.s_axi_arsize = 3'd3; bus.s_axi_arburst = 2'b01;
      bus.s_axi_awid = 13'h9; bus.s_axi_awaddr = 64'h500; bus.s_axi_awlen = 8'd0; bus.s_axi_awsize = 3'd3; bus.s_axi_awburst = 2'b01;
      bus.s_axi_arvalid = 1'b1; bus.s_axi_awvalid = 1'b1;
      #1;
      checks++; if (bus.s_axi_awready !== 1'b0 || bus.s_axi_arready !== 1'b1) begin errors++; $display("FAIL prio_ready: got ar%b aw%b want ar1 aw0", bus.s_axi_arready, bus.s_axi_awready); end
      step();
      bus.s_axi_arvalid = 1'b0; bus.s_axi_awvalid = 1'b0;
      #1;
      checks++; if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_wready !== 1'b0) begin errors++; $display("FAIL prio_state: got rvalid %b wready %b want 1 0", bus.s_axi_rvalid, bus.s_axi_wready); end
      checks++; if (bus.s_axi_rdata !== 64'h55 || bus.s_axi_rid !== 13'h7) begin errors++; $display("FAIL prio_rdata: got %h id %h want 55 id 7", bus.s_axi_rdata, bus.s_axi_rid); end
      bus.s_axi_rready = 1'b1;
      step();
      bus.s_axi_rready = 1'b0;
      checks++; if (bus.s_axi_arready !== 1'b1) begin errors++; $display("FAIL prio_idle: got arready %b want 1", bus.s_axi_arready); end
   endtask

   task automatic test_reset_abort();
      int lat; logic held;
      bus.s_axi_awaddr = 64'h200; bus.s_axi_awlen = 8'd3; bus.s_axi_awvalid = 1'b1;
      step();
      bus.s_axi_awvalid = 1'b0;
      checks++; if (bus.s_axi_wready !== 1'b1) begin errors++; $display("FAIL abort_pre_wready: got %b want 1", bus.s_axi_wready); end
      reset = 1'b1;
      #1;
      checks++; if (bus.s_axi_wready !== 1'b0 || bus.s_axi_arready !== 1'b0) begin errors++; $display("FAIL abort_async: got wready %b arready %b want 0 0", bus.s_axi_wready, bus.s_axi_arready); end
      step();
      reset = 1'b0;
      step();
      do_read(64'h200, 8'd0, 3'd3, 2'b01, -1, 0, lat, held);
      checks++; if (rd[0] !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL abort_mem_kept: got %h want ffffffff00000000", rd[0]); end
   endtask

`ifdef AXI_SNOOP_EN
   task automatic test_snoop();
      logic bq;
      bus.s_axi_acready = 1'b0;
      bus.s_axi_awaddr = 64'h1234; bus.s_axi_awlen = 8'd0; bus.s_axi_awsize = 3'd3; bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
      step();
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = 64'h77; bus.s_axi_wstrb = 8'hFF; bus.s_axi_wlast = 1'b1;
      step();
      bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
      checks++; if (bus.s_axi_acvalid !== 1'b1) begin errors++; $display("FAIL snoop_acvalid: got %b want 1", bus.s_axi_acvalid); end
      checks++; if (bus.s_axi_acaddr !== 64'h1200) begin errors++; $display("FAIL snoop_acaddr: got %h want 1200", bus.s_axi_acaddr); end
      checks++; if (bus.s_axi_acsnoop !== 4'hD) begin errors++; $display("FAIL snoop_acsnoop: got %h want d", bus.s_axi_acsnoop); end
      bq = bus.s_axi_bvalid;
      repeat (4) begin step(); bq |= bus.s_axi_bvalid; end
      checks++; if (bq !== 1'b0) begin errors++; $display("FAIL snoop_early_b: got %b want 0", bq); end
      bus.s_axi_acready = 1'b1;
      step();
      bus.s_axi_acready = 1'b0;
      checks++; if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_acvalid !== 1'b0) begin errors++; $display("FAIL snoop_b_after_ac: got bvalid %b acvalid %b want 1 0", bus.s_axi_bvalid, bus.s_axi_acvalid); end
      bus.s_axi_bready = 1'b1;
      step();
      bus.s_axi_bready = 1'b0;
      bus.s_axi_acready = 1'b1;
   endtask
`else
   task automatic test_snoop();
      logic [1:0] resp; logic [12:0] bid; int blat; logic bheld;
      bus.s_axi_acready = 1'b0;
      wd[0] = 64'h77;
      do_write(64'h1234, 8'd0, 3'd3, 2'b01, 1, 8'hFF, 0, resp, bid, blat, bheld);
      checks++; if (blat !== 0) begin errors++; $display("FAIL nosnoop_blat: got %0d want 0", blat); end
      checks++; if (bus.s_axi_acvalid !== 1'b0 || bus.s_axi_acaddr !== 64'h0) begin errors++; $display("FAIL nosnoop_ac: got %b %h want 0 0", bus.s_axi_acvalid, bus.s_axi_acaddr); end
      bus.s_axi_acready = 1'b1;
   endtask
`endif

   initial begin
      bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = 3'd3; bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
      bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = 3'd3; bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b0; bus.s_axi_acready = 1'b1;
      test_reset();
      test_incr();
      test_strobe();
      test_backpressure();
      test_wrap();
      test_errors();
      test_priority();
      test_reset_abort();
      test_snoop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 slave memory model that answers the AR/R and AW/W/B channels driven by the memory system's AXI master port, backed by an internal word array. It is the responder end of the interconnect's `m_axi_*` bus and serves as the simulation main memory for the I$/D$/MMU path. It serves one transaction at a time and implements FIXED, INCR and WRAP bursts with byte strobes. Optionally, it initiates AC snoops toward the caches after each write.

## Interface
- `ID_WIDTH`, 13, AXI ID width
- `ADDR_WIDTH`, 64, address width
- `DATA_WIDTH`, 64, data width; fixed at 64
- `STRB_WIDTH`, `DATA_WIDTH/8`, write strobe width
- `MEM_WORDS`, 4096, number of 64-bit words; power of two
- `clk` in 1: single clock; all logic on posedge
- `reset` in 1: asynchronous, active-high
- `s_axi_awid/awaddr/awlen/awsize/awburst` in ID/ADDR/8/3/2: write address
- `s_axi_awvalid` in 1, `s_axi_awready` out 1
- `s_axi_wdata/wstrb/wlast/wvalid` in DATA/STRB/1/1, `s_axi_wready` out 1
- `s_axi_bid/bresp/bvalid` out ID/2/1, `s_axi_bready` in 1
- `s_axi_arid/araddr/arlen/arsize/arburst/arvalid` in ID/ADDR/8/3/2/1, `s_axi_arready` out 1
- `s_axi_rid/rdata/rresp/rlast/rvalid` out ID/DATA/2/1/1, `s_axi_rready` in 1
- `s_axi_acvalid/acaddr/acsnoop` out 1/ADDR/4, `s_axi_acready` in 1: snoop initiator; tied to 0 without `AXI_SNOOP_EN`

## Operation
- **FSM states:** `IDLE`, `RD`, `WR_DATA`, `WR_SNOOP`, `WR_RESP`.
- **IDLE**
  - `arready=1`. `awready = !arvalid`, so reads take priority when both are valid.
  - An AR handshake latches id, addr, len, size and burst, clears the beat counter, and moves to `RD`.
  - An AW handshake latches the same fields and moves to `WR_DATA`.
- **RD**
  - `rvalid=1`, `rdata=mem[idx]`, `rid`=latched id.
  - `rlast=(beat==len)`.
  - On `rvalid&rready`, advance the address and beat. After the last beat, go to `IDLE`.
- **WR_DATA**
  - `wready=1`.
  - On each handshake, write the bytes whose strobe is set. Advance the address and beat.
  - On `wlast`, go to `WR_SNOOP` (macro on) or `WR_RESP`.
- **WR_SNOOP**
  - `acvalid=1`, `acaddr={start_addr[ADDR-1:6],6'b0}`, `acsnoop=4'hD` (invalidate).
  - On `acready`, go to `WR_RESP`.
- **WR_RESP**
  - `bvalid=1`, `bid`=latched id.
  - On `bready`, go to `IDLE`.
- **Address advance** (size `s` gives byte step `2^s`):
  - FIXED: the address is unchanged.
  - INCR: `addr += 2^s`.
  - WRAP: the address wraps within an aligned window of `(len+1)*2^s` bytes. `len+1` must be 2, 4, 8 or 16; any other value gives SLVERR.
- **Index and range:**
  - `idx = addr[$clog2(MEM_WORDS)+2:3]`.
  - A beat is out of range when `addr>>3 >= MEM_WORDS`. That beat returns `rdata=0` / drops the write and sets DECERR (2'b11).
- **Error responses:**
  - `size>3` gives SLVERR (2'b10). Reads return 0 and writes are dropped.
  - A write whose beat count is not `len+1` at `wlast` gives SLVERR. The block still waits for `wlast`.
  - `rresp` is per beat. `bresp` is the worst case (DECERR > SLVERR > OKAY) over all beats.
- `reset` mid-transaction aborts it and returns to `IDLE`. Memory contents are not cleared.

## Timing
- **Reset values:** all valid/ready outputs are 0; `rdata`, `rid`, `rresp`, `rlast`, `bid`, `bresp`, `acaddr` and `acsnoop` are 0; state is `IDLE`.
- **Read latency:**
  - An AR handshake at cycle N puts the first beat at N+1.
  - Beats are back-to-back while `rready` is high.
  - R outputs hold stable while `rvalid & !rready`.
- **Write latency:**
  - AW at N gives `wready` at N+1; each W beat takes 1 cycle.
  - The last W at M gives `bvalid` at M+1, or `acvalid` at M+1 when `AXI_SNOOP_EN` is defined.
  - With snoop, `bvalid` comes 1 cycle after the AC handshake.
- **Read-after-write:** a read issued after B completes returns the newly written data.
- Exactly one transaction is outstanding. `arready` and `awready` are 0 outside `IDLE`.

## Configuration
- `AXI_SNOOP_EN` defined: the `WR_SNOOP` state is present and every write burst is followed by one invalidate snoop of its 64-byte line before B.
- `AXI_SNOOP_EN` undefined: `WR_SNOOP` is removed, `acvalid`/`acaddr`/`acsnoop` are tied to 0, `acready` is ignored, and `WR_DATA` goes directly to `WR_RESP`.

## Test plan
- INCR write, 8 beats: AW addr=0x100, len=7, size=3, data 0x11..0x88 with full strobes. Then INCR read of the same range returns the same 8 words with OKAY, and `rlast` is high only on beat 8.
- Strobe test: write 0xFFFF_FFFF_FFFF_FFFF to 0x200, then write 0x0 with wstrb=0x0F. A read of 0x200 returns 0xFFFF_FFFF_0000_0000.
- WRAP read, len=3, araddr=0x118, with words at 0x100..0x118 preloaded to 0..3. Beats return words 3, 0, 1, 2.
- Backpressure: `rready` low for 3 cycles mid-burst. `rdata`/`rlast` hold stable and no beat is dropped. `bready` delayed 5 cycles keeps `bvalid` high.
- Errors:
  - Read at `araddr=MEM_WORDS*8` returns rdata=0 with rresp=2'b11.
  - Write with awlen=3 and `wlast` on beat 2 returns bresp=2'b10.
  - Simultaneous arvalid/awvalid: the AR is accepted first.
- With `AXI_SNOOP_EN`: a write to 0x1234 gives acvalid with acaddr=0x1200 and acsnoop=0xD. With `acready` held low for 4 cycles, `bvalid` does not assert until 1 cycle after `acready`.
